// File: rtl/vgalcd_timgen_if.sv
// Signal bundle between the vgalcd register file / pixel path and the timing generator.
// The line-interrupt signals exist only when VGALCD_TIMGEN_LINEIRQ_EN is defined.
interface vgalcd_timgen_if #(
   parameter int HCNT_WIDTH  = 12,
   parameter int VCNT_WIDTH  = 12,
   parameter int PORCH_WIDTH = 10,
   parameter int DIV_WIDTH   = 8
);
   logic                   en_i;
   logic [DIV_WIDTH-1:0]   div_i;
   logic [PORCH_WIDTH-1:0] hbp_i, hsn_i, hfp_i;
   logic [HCNT_WIDTH-1:0]  hvlen_i;
   logic [PORCH_WIDTH-1:0] vbp_i, vsn_i, vfp_i;
   logic [VCNT_WIDTH-1:0]  vvlen_i;
   logic                   hpol_i, vpol_i;
   logic                   cfg_upd_i;
   logic                   cfg_ack_o;
   logic                   pix_tick_o;
   logic                   hsync_o, vsync_o;
   logic                   de_o;
   logic [HCNT_WIDTH-1:0]  xpos_o;
   logic [VCNT_WIDTH-1:0]  ypos_o;
   logic                   line_end_o, frame_end_o;
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
   logic [VCNT_WIDTH-1:0]  irq_line_i;
   logic                   line_irq_o;
`endif

   modport master (
      output en_i, div_i, hbp_i, hsn_i, hfp_i, hvlen_i, vbp_i, vsn_i, vfp_i, vvlen_i,
             hpol_i, vpol_i, cfg_upd_i,
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      output irq_line_i,
      input  line_irq_o,
`endif
      input  cfg_ack_o, pix_tick_o, hsync_o, vsync_o, de_o, xpos_o, ypos_o,
             line_end_o, frame_end_o
   );

   modport slave (
      input  en_i, div_i, hbp_i, hsn_i, hfp_i, hvlen_i, vbp_i, vsn_i, vfp_i, vvlen_i,
             hpol_i, vpol_i, cfg_upd_i,
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      input  irq_line_i,
      output line_irq_o,
`endif
      output cfg_ack_o, pix_tick_o, hsync_o, vsync_o, de_o, xpos_o, ypos_o,
             line_end_o, frame_end_o
   );
endinterface

// File: rtl/vgalcd_timgen.sv
// Two-axis VGA/LCD timing generator with pixel prescaler and frame-synchronous shadow config.
// Optional line interrupt compare enabled by defining VGALCD_TIMGEN_LINEIRQ_EN.
module vgalcd_timgen #(
   parameter int HCNT_WIDTH  = 12,
   parameter int VCNT_WIDTH  = 12,
   parameter int PORCH_WIDTH = 10,
   parameter int DIV_WIDTH   = 8
) (
   input logic            clk_i,
   input logic            rst_i,
   vgalcd_timgen_if.slave tg_io
);
   localparam int HVW = (HCNT_WIDTH > VCNT_WIDTH) ? HCNT_WIDTH : VCNT_WIDTH;
   localparam int CW  = (HVW > PORCH_WIDTH) ? HVW : PORCH_WIDTH;

   typedef enum logic [1:0] {ST_BP, ST_VIS, ST_FP, ST_SYNC} phase_e;

   typedef struct packed {
      logic [DIV_WIDTH-1:0]   div;
      logic [PORCH_WIDTH-1:0] hbp, hsn, hfp;
      logic [HCNT_WIDTH-1:0]  hvlen;
      logic [PORCH_WIDTH-1:0] vbp, vsn, vfp;
      logic [VCNT_WIDTH-1:0]  vvlen;
      logic                   hpol, vpol;
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      logic [VCNT_WIDTH-1:0]  irq_line;
`endif
   } shadow_t;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         ST_BP:   return ST_VIS;
         ST_VIS:  return ST_FP;
         ST_FP:   return ST_SYNC;
         default: return ST_BP;
      endcase
   endfunction

   function automatic logic [CW-1:0] field_for(input phase_e p, input logic [CW-1:0] bp,
                                               input logic [CW-1:0] vis, input logic [CW-1:0] fp,
                                               input logic [CW-1:0] sn);
      case (p)
         ST_BP:   return bp;
         ST_VIS:  return vis;
         ST_FP:   return fp;
         default: return sn;
      endcase
   endfunction

   shadow_t              shd_q, shd_d, cfg_in;
   logic [DIV_WIDTH-1:0] presc_q, presc_d;
   phase_e               hst_q, hst_d, vst_q, vst_d;
   logic [CW-1:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic                 pend_q, pend_d;
   logic                 ack_q, ack_d;
   logic                 idle, tick, line_end, frame_end, upd_now;
   logic [HCNT_WIDTH-1:0] xpos;
   logic [VCNT_WIDTH-1:0] ypos;

   always_comb begin
      cfg_in          = '0;
      cfg_in.div      = tg_io.div_i;
      cfg_in.hbp      = tg_io.hbp_i;
      cfg_in.hsn      = tg_io.hsn_i;
      cfg_in.hfp      = tg_io.hfp_i;
      cfg_in.hvlen    = tg_io.hvlen_i;
      cfg_in.vbp      = tg_io.vbp_i;
      cfg_in.vsn      = tg_io.vsn_i;
      cfg_in.vfp      = tg_io.vfp_i;
      cfg_in.vvlen    = tg_io.vvlen_i;
      cfg_in.hpol     = tg_io.hpol_i;
      cfg_in.vpol     = tg_io.vpol_i;
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      cfg_in.irq_line = tg_io.irq_line_i;
`endif

      idle      = rst_i | ~tg_io.en_i;
      tick      = ~idle & (presc_q == shd_q.div);
      line_end  = tick & (hst_q == ST_SYNC) & (hcnt_q == '0);
      frame_end = line_end & (vst_q == ST_SYNC) & (vcnt_q == '0);
      upd_now   = frame_end & (pend_q | tg_io.cfg_upd_i);

      // Shadows follow the inputs while idle; otherwise they load only at a frame boundary,
      // and the counters below reload from shd_d so the new frame starts on the new values.
      shd_d = (idle | upd_now) ? cfg_in : shd_q;

      presc_d = (idle | tick) ? '0 : presc_q + DIV_WIDTH'(1);

      hst_d  = hst_q;
      hcnt_d = hcnt_q;
      vst_d  = vst_q;
      vcnt_d = vcnt_q;
      if (idle) begin
         hst_d  = ST_BP;
         hcnt_d = CW'(shd_d.hbp);
         vst_d  = ST_BP;
         vcnt_d = CW'(shd_d.vbp);
      end else begin
         if (tick) begin
            if (hcnt_q == '0) begin
               hst_d  = next_phase(hst_q);
               hcnt_d = field_for(hst_d, CW'(shd_d.hbp), CW'(shd_d.hvlen),
                                  CW'(shd_d.hfp), CW'(shd_d.hsn));
            end else begin
               hcnt_d = hcnt_q - CW'(1);
            end
         end
         if (line_end) begin
            if (vcnt_q == '0) begin
               vst_d  = next_phase(vst_q);
               vcnt_d = field_for(vst_d, CW'(shd_d.vbp), CW'(shd_d.vvlen),
                                  CW'(shd_d.vfp), CW'(shd_d.vsn));
            end else begin
               vcnt_d = vcnt_q - CW'(1);
            end
         end
      end

      pend_d = pend_q;
      if (idle | upd_now)         pend_d = 1'b0;
      else if (tg_io.cfg_upd_i)   pend_d = 1'b1;

      ack_d = ~rst_i & ((~tg_io.en_i & tg_io.cfg_upd_i) | upd_now);

      xpos = (hst_q == ST_VIS) ? shd_q.hvlen - HCNT_WIDTH'(hcnt_q) : '0;
      ypos = (vst_q == ST_VIS) ? shd_q.vvlen - VCNT_WIDTH'(vcnt_q) : '0;
   end

   always_ff @(posedge clk_i) begin
      shd_q   <= shd_d;
      presc_q <= presc_d;
      hst_q   <= hst_d;
      hcnt_q  <= hcnt_d;
      vst_q   <= vst_d;
      vcnt_q  <= vcnt_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
   end

   assign tg_io.cfg_ack_o   = ack_q;
   assign tg_io.pix_tick_o  = tick;
   assign tg_io.line_end_o  = line_end;
   assign tg_io.frame_end_o = frame_end;
   assign tg_io.de_o        = (hst_q == ST_VIS) & (vst_q == ST_VIS);
   assign tg_io.xpos_o      = xpos;
   assign tg_io.ypos_o      = ypos;
   assign tg_io.hsync_o     = (hst_q == ST_SYNC) ~^ shd_q.hpol;
   assign tg_io.vsync_o     = (vst_q == ST_SYNC) ~^ shd_q.vpol;
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
   assign tg_io.line_irq_o  = line_end & (vst_q == ST_VIS) & (ypos == shd_q.irq_line);
`endif
endmodule

// File: tb/tb_vgalcd_timgen.sv
// Directed bench for vgalcd_timgen: reset, small-frame timing, prescaler, enable drop,
// frame-synchronous config update, sync polarity and (if built in) the line interrupt.
module tb_vgalcd_timgen;
   localparam int HW = 12;
   localparam int VW = 12;
   localparam int PW = 10;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vgalcd_timgen_if #(.HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .PORCH_WIDTH(PW), .DIV_WIDTH(DW)) tg ();

   vgalcd_timgen #(.HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .PORCH_WIDTH(PW), .DIV_WIDTH(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .tg_io (tg)
   );

   int checks   = 0;
   int failures = 0;

   int le_cnt, le_first, fe_cnt, fe_first, hs_cnt, vs_cnt, de_cnt, de_first;
   int de_run, de_run_max, tick_cnt, tick_first, ack_cnt, ack_first, hold_viol;
   int irq_cnt, irq_first, de_seen;
   logic [31:0] xs, ys;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Observe n cycles starting at the current negedge; statistics are window-relative.
   task automatic window(input int n);
      logic [26:0] prev, cur;
      logic        prev_tick;
      le_cnt = 0; le_first = -1; fe_cnt = 0; fe_first = -1; hs_cnt = 0; vs_cnt = 0;
      de_cnt = 0; de_first = -1; de_run = 0; de_run_max = 0; tick_cnt = 0; tick_first = -1;
      ack_cnt = 0; ack_first = -1; hold_viol = 0; irq_cnt = 0; irq_first = -1; de_seen = 0;
      xs = '0; ys = '0; prev = '0; prev_tick = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         cur = {tg.hsync_o, tg.vsync_o, tg.de_o, tg.xpos_o, tg.ypos_o};
         if (i > 0 && !prev_tick && cur !== prev) hold_viol++;
         if (tg.pix_tick_o) begin tick_cnt++; if (tick_first < 0) tick_first = i; end
         if (tg.line_end_o) begin le_cnt++; if (le_first < 0) le_first = i; end
         if (tg.frame_end_o) begin fe_cnt++; if (fe_first < 0) fe_first = i; end
         if (tg.cfg_ack_o) begin ack_cnt++; if (ack_first < 0) ack_first = i; end
         if (tg.hsync_o) hs_cnt++;
         if (tg.vsync_o) vs_cnt++;
         if (tg.de_o) begin
            de_cnt++;
            de_run++;
            if (de_run > de_run_max) de_run_max = de_run;
            if (de_first < 0) de_first = i;
            if (de_seen < 8) begin
               xs = {xs[27:0], tg.xpos_o[3:0]};
               ys = {ys[27:0], tg.ypos_o[3:0]};
               de_seen++;
            end
         end else begin
            de_run = 0;
         end
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
         if (tg.line_irq_o) begin irq_cnt++; if (irq_first < 0) irq_first = i; end
`endif
         prev      = cur;
         prev_tick = tg.pix_tick_o;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      tg.en_i = 1'b1; tg.div_i = 8'd0;
      tg.hbp_i = 10'd1; tg.hvlen_i = 12'd3; tg.hfp_i = 10'd0; tg.hsn_i = 10'd1;
      tg.vbp_i = 10'd0; tg.vvlen_i = 12'd1; tg.vfp_i = 10'd0; tg.vsn_i = 10'd0;
      tg.hpol_i = 1'b1; tg.vpol_i = 1'b1; tg.cfg_upd_i = 1'b0;
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      tg.irq_line_i = 12'd1;
`endif

      // reset held for three clocks with the generator enabled
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_hsync", tg.hsync_o, 0);
      check_val("rst_vsync", tg.vsync_o, 0);
      check_val("rst_de", tg.de_o, 0);
      check_val("rst_xpos", tg.xpos_o, 0);
      check_val("rst_ypos", tg.ypos_o, 0);
      check_val("rst_tick", tg.pix_tick_o, 0);
      check_val("rst_line_end", tg.line_end_o, 0);
      check_val("rst_frame_end", tg.frame_end_o, 0);
      check_val("rst_cfg_ack", tg.cfg_ack_o, 0);

      // div=0 small frame: 9-cycle lines, 5 lines per frame
      @(negedge clk);
      rst = 1'b0;
      window(45);
      check_val("d0_tick_cnt", tick_cnt, 45);
      check_val("d0_le_first", le_first, 8);
      check_val("d0_le_cnt", le_cnt, 5);
      check_val("d0_fe_first", fe_first, 44);
      check_val("d0_hsync_cnt", hs_cnt, 10);
      check_val("d0_vsync_cnt", vs_cnt, 9);
      check_val("d0_de_cnt", de_cnt, 8);
      check_val("d0_de_first", de_first, 11);
      check_val("d0_xpos_seq", xs, 32'h0123_0123);
      check_val("d0_ypos_seq", ys, 32'h0000_1111);
      window(45);
      check_val("d0_fe_period", fe_first, 44);
      check_val("d0_fe_cnt", fe_cnt, 1);

      // div=2: one tick every third clock, 135-cycle frames
      tg.en_i = 1'b0; tg.div_i = 8'd2;
      @(negedge clk);
      tg.en_i = 1'b1;
      window(135);
      check_val("d2_tick_first", tick_first, 2);
      check_val("d2_tick_cnt", tick_cnt, 45);
      check_val("d2_le_first", le_first, 26);
      check_val("d2_fe_first", fe_first, 134);
      check_val("d2_de_cnt", de_cnt, 24);
      check_val("d2_de_first", de_first, 33);
      check_val("d2_hold", hold_viol, 0);
      window(135);
      check_val("d2_fe_period", fe_first, 134);

      // enable drop while visible, then re-enable
      tg.en_i = 1'b0; tg.div_i = 8'd0;
      @(negedge clk);
      tg.en_i = 1'b1;
      window(13);
      check_val("en_de_first", de_first, 11);
      tg.en_i = 1'b0;
      #1;
      check_val("en_de_before_drop", tg.de_o, 1);
      check_val("en_xpos_before_drop", tg.xpos_o, 2);
      @(negedge clk);
      tg.en_i = 1'b1;
      #1;
      check_val("en_off_de", tg.de_o, 0);
      check_val("en_off_hsync", tg.hsync_o, 0);
      check_val("en_off_vsync", tg.vsync_o, 0);
      check_val("en_off_xpos", tg.xpos_o, 0);
      check_val("en_off_ypos", tg.ypos_o, 0);
      window(20);
      check_val("en_re_le_first", le_first, 8);

      // mid-frame config update: current frame unchanged, next frame 11-cycle lines
      tg.hvlen_i = 12'd5; tg.cfg_upd_i = 1'b1;
      window(1);
      check_val("upd_no_early_ack", ack_cnt, 0);
      tg.cfg_upd_i = 1'b0;
      window(25);
      check_val("upd_old_le_first", le_first, 5);
      check_val("upd_old_le_cnt", le_cnt, 3);
      check_val("upd_fe_first", fe_first, 23);
      check_val("upd_ack_first", ack_first, 24);
      check_val("upd_ack_cnt", ack_cnt, 1);
      window(55);
      check_val("upd_new_le_first", le_first, 9);
      check_val("upd_new_fe_first", fe_first, 53);
      check_val("upd_new_de_width", de_run_max, 6);
      check_val("upd_new_de_cnt", de_cnt, 12);
      check_val("upd_new_ack_cnt", ack_cnt, 0);

      // active-low syncs; cfg_upd while disabled acks on the next cycle
      tg.en_i = 1'b0; tg.hvlen_i = 12'd3; tg.hpol_i = 1'b0; tg.vpol_i = 1'b0;
      tg.cfg_upd_i = 1'b1;
      @(negedge clk);
      tg.cfg_upd_i = 1'b0; tg.en_i = 1'b1;
      #1;
      check_val("dis_ack", tg.cfg_ack_o, 1);
      check_val("pol_idle_hsync", tg.hsync_o, 1);
      check_val("pol_idle_vsync", tg.vsync_o, 1);
      window(45);
      check_val("dis_ack_one_cycle", ack_cnt, 1);
      check_val("pol_hsync_high_cnt", hs_cnt, 35);
      check_val("pol_vsync_high_cnt", vs_cnt, 36);
      check_val("pol_fe_first", fe_first, 44);
`ifdef VGALCD_TIMGEN_LINEIRQ_EN
      check_val("irq_cnt", irq_cnt, 1);
      check_val("irq_first", irq_first, 26);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
